// File: rtl/mac_out_axis_packer_pkg.sv
// Shared types and helpers for the MAC output AXIS packer.
package mac_out_axis_packer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so that single-entry counters still get a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int in_w_of(input int word_w, input int in_lanes);
    return word_w * in_lanes;
  endfunction

  function automatic int tdata_w_of(input int word_w, input int beat_words);
    return word_w * beat_words;
  endfunction

  function automatic int beats_max_of(input int in_lanes, input int beat_words);
    return in_lanes / beat_words;
  endfunction

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_IN_LANES   = 8;
  localparam int DEF_BEAT_WORDS = 1;
  localparam int IN_W           = DEF_WORD_W * DEF_IN_LANES;
  localparam int TDATA_W        = DEF_WORD_W * DEF_BEAT_WORDS;
  localparam int KEEP_W         = TDATA_W / 8;
  localparam int BEATS_MAX      = DEF_IN_LANES / DEF_BEAT_WORDS;
  localparam int BEAT_CNT_W     = clog2(BEATS_MAX);

endpackage

// File: rtl/mac_out_axis_packer_beat_select.sv
// Beat mux: picks the current beat's words from the captured vector, zeroing and
// clearing keep for words beyond the valid word count. Purely combinational.
module mac_out_beat_select #(
  parameter int WORD_W     = 32,
  parameter int IN_LANES   = 8,
  parameter int BEAT_WORDS = 1,
  parameter int BC_W       = 3,
  parameter int WD_W       = 4
) (
  input  logic [IN_LANES*WORD_W-1:0]     vec,
  input  logic [BC_W-1:0]                beat_cnt,
  input  logic [WD_W-1:0]                words,
  output logic [BEAT_WORDS*WORD_W-1:0]   tdata,
  output logic [BEAT_WORDS*WORD_W/8-1:0] tkeep
);

  localparam int WB = WORD_W / 8;

  always_comb begin
    tdata = '0;
    tkeep = '0;
    for (int j = 0; j < BEAT_WORDS; j++) begin
      for (int k = 0; k < IN_LANES; k++) begin
        if ((k == int'(beat_cnt) * BEAT_WORDS + j) && (k < int'(words))) begin
          tdata[j*WORD_W +: WORD_W] = vec[k*WORD_W +: WORD_W];
          tkeep[j*WB +: WB]         = '1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_out_axis_packer.sv
// Serialises one captured MAC vector into AXIS beats; first beat one cycle after capture.
// Holds beats under m_tready=0; s_ready reopens combinationally on the accepted final beat.
module mac_out_axis_packer
  import mac_out_axis_packer_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int IN_LANES    = 8,
  parameter int BEAT_WORDS  = 1,
  parameter int CH_PER_WORD = 32,
  parameter int CH_W        = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CH_W-1:0]                   cfg_channels,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [IN_LANES*WORD_W-1:0]        s_data,
  input  logic                              s_last,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [BEAT_WORDS*WORD_W-1:0]      m_tdata,
  output logic [BEAT_WORDS*WORD_W/8-1:0]    m_tkeep,
  output logic                              m_tlast,
  output logic                              vec_done,
  output logic                              layer_done
);

  localparam int L_IN_W      = in_w_of(WORD_W, IN_LANES);
  localparam int L_TDATA_W   = tdata_w_of(WORD_W, BEAT_WORDS);
  localparam int L_KEEP_W    = L_TDATA_W / 8;
  localparam int L_BEATS_MAX = beats_max_of(IN_LANES, BEAT_WORDS);
  localparam int BC_W        = clog2(L_BEATS_MAX);
  localparam int BT_W        = clog2(L_BEATS_MAX + 1);
  localparam int WD_W        = clog2(IN_LANES + 1);

  state_t             state, state_nxt;
  logic [BC_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [L_IN_W-1:0]  vec_q;
  logic               last_q;
  logic [WD_W-1:0]    words_q, words_in;
  logic [BT_W-1:0]    beats_q, beats_in;
  logic               ready_en;
  logic               final_beat;
  logic               out_hs;
  logic               capture;
  int                 words_int;
  logic [L_TDATA_W-1:0] sel_data;
  logic [L_KEEP_W-1:0]  sel_keep;

  // Word count clamped to 1..IN_LANES so an empty layer still emits one beat.
  always_comb begin
    words_int = (int'(cfg_channels) + CH_PER_WORD - 1) / CH_PER_WORD;
    if (words_int < 1) begin
      words_int = 1;
    end else if (words_int > IN_LANES) begin
      words_int = IN_LANES;
    end
    words_in = WD_W'(words_int);
    beats_in = BT_W'((words_int + BEAT_WORDS - 1) / BEAT_WORDS);
  end

  assign final_beat = (state == SEND) && (int'(beat_cnt) == int'(beats_q) - 1);
  assign out_hs     = (state == SEND) && m_tready;
  assign s_ready    = ready_en && ((state == IDLE) || (final_beat && m_tready));
  assign capture    = s_valid && s_ready;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt    = SEND;
          beat_cnt_nxt = '0;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (final_beat) begin
            beat_cnt_nxt = '0;
            state_nxt    = capture ? SEND : IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      ready_en   <= 1'b0;
      vec_q      <= '0;
      last_q     <= 1'b0;
      words_q    <= '0;
      beats_q    <= '0;
      vec_done   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      ready_en   <= 1'b1;
      vec_done   <= out_hs && final_beat;
      layer_done <= out_hs && final_beat && last_q;
      if (capture) begin
        vec_q   <= s_data;
        last_q  <= s_last;
        words_q <= words_in;
        beats_q <= beats_in;
      end
    end
  end

  mac_out_beat_select #(
    .WORD_W     (WORD_W),
    .IN_LANES   (IN_LANES),
    .BEAT_WORDS (BEAT_WORDS),
    .BC_W       (BC_W),
    .WD_W       (WD_W)
  ) u_beat_select (
    .vec      (vec_q),
    .beat_cnt (beat_cnt),
    .words    (words_q),
    .tdata    (sel_data),
    .tkeep    (sel_keep)
  );

  // Outputs are forced to zero outside SEND so they read as idle after reset.
  assign m_tvalid = (state == SEND);
  assign m_tdata  = m_tvalid ? sel_data : '0;
  assign m_tkeep  = m_tvalid ? sel_keep : '0;
  assign m_tlast  = final_beat && last_q;

endmodule

// File: tb/tb_mac_out_axis_packer.sv
// Directed bench for mac_out_axis_packer: default instance plus a two-word-beat instance.
module tb_mac_out_axis_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [11:0]  cfg_channels = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tlast;
  logic         vec_done;
  logic         layer_done;

  logic [11:0]  cfg2 = '0;
  logic         s_valid2 = 1'b0;
  logic         s_ready2;
  logic [255:0] s_data2 = '0;
  logic         s_last2 = 1'b0;
  logic         m_tvalid2;
  logic         m_tready2 = 1'b1;
  logic [63:0]  m_tdata2;
  logic [7:0]   m_tkeep2;
  logic         m_tlast2;
  logic         vec_done2;
  logic         layer_done2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_out_axis_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_channels (cfg_channels),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .vec_done     (vec_done),
    .layer_done   (layer_done)
  );

  mac_out_axis_packer #(.BEAT_WORDS(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_channels (cfg2),
    .s_valid      (s_valid2),
    .s_ready      (s_ready2),
    .s_data       (s_data2),
    .s_last       (s_last2),
    .m_tvalid     (m_tvalid2),
    .m_tready     (m_tready2),
    .m_tdata      (m_tdata2),
    .m_tkeep      (m_tkeep2),
    .m_tlast      (m_tlast2),
    .vec_done     (vec_done2),
    .layer_done   (layer_done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [31:0] base);
    for (int i = 0; i < 8; i++) s_data[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic set_vec2(input logic [31:0] base);
    for (int i = 0; i < 8; i++) s_data2[i*32 +: 32] = base + 32'(i);
  endtask

  int tv_cnt;
  logic [0:5] rdy_seq;
  int exp_idx [6];

  initial begin
    // Reset state
    step();
    step();
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_vec_done", 64'(vec_done), 64'd0);
    chk("rst_layer_done", 64'(layer_done), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready_0", 64'(s_ready), 64'd0);
    step();
    chk("rel_s_ready_1", 64'(s_ready), 64'd1);
    chk("rel_tvalid", 64'(m_tvalid), 64'd0);

    // Full 8-beat vector, no stall
    cfg_channels = 12'd256;
    set_vec(32'h0);
    s_last  = 1'b1;
    s_valid = 1'b1;
    m_tready = 1'b1;
    step();
    s_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("full_tvalid_b%0d", b), 64'(m_tvalid), 64'd1);
      chk($sformatf("full_tdata_b%0d", b), 64'(m_tdata), 64'(b));
      chk($sformatf("full_tkeep_b%0d", b), 64'(m_tkeep), 64'hF);
      chk($sformatf("full_tlast_b%0d", b), 64'(m_tlast), 64'(b == 7));
      chk($sformatf("full_vec_done_b%0d", b), 64'(vec_done), 64'd0);
      step();
    end
    chk("full_vec_done", 64'(vec_done), 64'd1);
    chk("full_layer_done", 64'(layer_done), 64'd1);
    chk("full_tvalid_end", 64'(m_tvalid), 64'd0);
    step();
    chk("full_vec_done_once", 64'(vec_done), 64'd0);
    chk("full_layer_done_once", 64'(layer_done), 64'd0);

    // Two words per beat, 3 valid words
    cfg2 = 12'd70;
    set_vec2(32'h10);
    s_last2  = 1'b1;
    s_valid2 = 1'b1;
    step();
    s_valid2 = 1'b0;
    chk("bw2_tdata_b0", m_tdata2, 64'h00000011_00000010);
    chk("bw2_tkeep_b0", 64'(m_tkeep2), 64'hFF);
    chk("bw2_tlast_b0", 64'(m_tlast2), 64'd0);
    step();
    chk("bw2_tdata_b1", m_tdata2, 64'h00000000_00000012);
    chk("bw2_tkeep_b1", 64'(m_tkeep2), 64'h0F);
    chk("bw2_tlast_b1", 64'(m_tlast2), 64'd1);
    step();
    chk("bw2_tvalid_end", 64'(m_tvalid2), 64'd0);
    chk("bw2_layer_done", 64'(layer_done2), 64'd1);

    // Backpressure during a 4-beat vector
    rdy_seq = 6'b100111;
    exp_idx = '{0, 1, 1, 1, 2, 3};
    cfg_channels = 12'd128;
    set_vec(32'hA0);
    s_last  = 1'b0;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    set_vec(32'h55);
    cfg_channels = 12'd32;
    tv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      m_tready = rdy_seq[c];
      #1;
      if (m_tvalid) tv_cnt++;
      chk($sformatf("stall_tdata_c%0d", c), 64'(m_tdata), 64'(32'hA0 + 32'(exp_idx[c])));
      chk($sformatf("stall_tkeep_c%0d", c), 64'(m_tkeep), 64'hF);
      chk($sformatf("stall_tlast_c%0d", c), 64'(m_tlast), 64'd0);
      step();
    end
    m_tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (m_tvalid) tv_cnt++;
      step();
    end
    chk("stall_tvalid_cycles", 64'(tv_cnt), 64'd6);

    // Back-to-back vectors, no bubble
    cfg_channels = 12'd64;
    set_vec(32'hB0);
    s_last  = 1'b0;
    s_valid = 1'b1;
    step();
    set_vec(32'hC0);
    s_last = 1'b1;
    chk("b2b_A0_s_ready", 64'(s_ready), 64'd0);
    chk("b2b_A0_tdata", 64'(m_tdata), 64'hB0);
    step();
    chk("b2b_A1_tdata", 64'(m_tdata), 64'hB1);
    chk("b2b_A1_s_ready", 64'(s_ready), 64'd1);
    chk("b2b_A1_tlast", 64'(m_tlast), 64'd0);
    step();
    s_valid = 1'b0;
    chk("b2b_B0_tvalid", 64'(m_tvalid), 64'd1);
    chk("b2b_B0_tdata", 64'(m_tdata), 64'hC0);
    chk("b2b_B0_tlast", 64'(m_tlast), 64'd0);
    chk("b2b_A_vec_done", 64'(vec_done), 64'd1);
    chk("b2b_A_layer_done", 64'(layer_done), 64'd0);
    step();
    chk("b2b_B1_tdata", 64'(m_tdata), 64'hC1);
    chk("b2b_B1_tlast", 64'(m_tlast), 64'd1);
    step();
    chk("b2b_end_tvalid", 64'(m_tvalid), 64'd0);
    chk("b2b_B_layer_done", 64'(layer_done), 64'd1);

    // Clamp low: zero channels gives one beat
    cfg_channels = 12'd0;
    set_vec(32'hD0);
    s_last  = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("clamp0_tdata", 64'(m_tdata), 64'hD0);
    chk("clamp0_tlast", 64'(m_tlast), 64'd1);
    step();
    chk("clamp0_tvalid_end", 64'(m_tvalid), 64'd0);

    // Clamp high: 4095 channels gives IN_LANES beats
    cfg_channels = 12'd4095;
    set_vec(32'h20);
    s_last  = 1'b0;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    tv_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_tvalid) tv_cnt++;
      if (c == 7) chk("clamp_hi_last_word", 64'(m_tdata), 64'h27);
      step();
    end
    chk("clamp_hi_beats", 64'(tv_cnt), 64'd8);

    // Reset during beat 2
    cfg_channels = 12'd256;
    set_vec(32'hE0);
    s_last  = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    step();
    chk("rstmid_tdata_b2", 64'(m_tdata), 64'hE2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", 64'(m_tvalid), 64'd0);
    chk("rstmid_s_ready", 64'(s_ready), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rstmid_idle_s_ready", 64'(s_ready), 64'd1);
    chk("rstmid_idle_tvalid", 64'(m_tvalid), 64'd0);
    set_vec(32'hF0);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("rstmid_new_b0", 64'(m_tdata), 64'hF0);
    chk("rstmid_new_tkeep", 64'(m_tkeep), 64'hF);
    step();
    chk("rstmid_new_b1", 64'(m_tdata), 64'hF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_out_axis_packer.md
Name: mac_out_axis_packer

Overview:
Serialises one wide MAC/pooling result vector into a stream of AXI-Stream beats.
Successor to the fixed 256-bit/32-bit pooling output packager, with these additions:
- parametrised vector width and beat width;
- AXIS backpressure (m_tready) and upstream flow control (s_ready);
- TKEEP for a partial final beat;
- per-vector last flag;
- back-to-back vectors with no bubble cycle.
Sits between the MAC array output and the output AXIS DMA channel.

Parameters:
WORD_W, 32, width of one output word in bits (multiple of 8)
IN_LANES, 8, number of words in one MAC result vector; IN_W = IN_LANES*WORD_W
BEAT_WORDS, 1, words per AXIS beat; TDATA_W = BEAT_WORDS*WORD_W; must divide IN_LANES
CH_PER_WORD, 32, channels packed in one word
CH_W, 12, width of the channel-count configuration field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_channels  in  CH_W  channels in the current layer; sampled at each input handshake
s_valid  in  1  MAC result vector valid
s_ready  out  1  packer can accept a vector
s_data  in  IN_W  MAC result vector; word i = s_data[i*WORD_W +: WORD_W]
s_last  in  1  vector is the final one of the layer; qualified by s_valid
m_tvalid  out  1  AXIS beat valid
m_tready  in  1  downstream ready
m_tdata  out  TDATA_W  beat data
m_tkeep  out  TDATA_W/8  byte enables
m_tlast  out  1  final beat of the final vector of the layer
vec_done  out  1  one-cycle pulse: final beat of a vector accepted
layer_done  out  1  one-cycle pulse: beat with m_tlast accepted

Behaviour:
- Word count: words = ceil(cfg_channels/CH_PER_WORD), clamped to the range 1..IN_LANES (cfg_channels=0 gives 1 word).
- Beat count: beats = ceil(words/BEAT_WORDS).
- All three values are computed at the input handshake and held in registers.
- States:
  - IDLE: s_ready=1. On s_valid, capture s_data, s_last, words and beats, then go to SEND.
  - SEND: beat_cnt counts 0..beats-1. Advance only on an m_tvalid&&m_tready handshake.
- Leaving SEND on the final-beat handshake:
  - if s_valid is also high that cycle, capture the next vector and stay in SEND with beat_cnt=0 (zero bubble);
  - otherwise go to IDLE.
- s_ready = (state==IDLE) | (state==SEND & final beat & m_tready). This path is combinational from m_tready; it is documented and permitted.
- m_tvalid = (state==SEND). The first beat is valid on the cycle after the input handshake (latency 1).
- While m_tvalid=1 and m_tready=0, m_tdata, m_tkeep and m_tlast hold stable.
- m_tdata for beat b = words b*BEAT_WORDS .. b*BEAT_WORDS+BEAT_WORDS-1 of the captured vector.
- Words at index >= words are driven as zero, and their m_tkeep bytes are 0. All other m_tkeep bytes are 1.
- m_tlast = final beat & captured s_last.
- vec_done and layer_done are registered: they pulse the cycle after the qualifying handshake.
- Changes to cfg_channels or s_data after capture have no effect on the vector in flight.
- Reset values: state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, vec_done=0, layer_done=0, beat_cnt=0. s_ready=1 one cycle after reset deassertion; it is 0 while rst_n=0.
- Reset mid-transfer: the in-flight vector is dropped, no partial-frame recovery, and m_tvalid falls asynchronously.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SEND);
  - clog2 function;
  - derived localparams: IN_W, TDATA_W, KEEP_W, BEATS_MAX = IN_LANES/BEAT_WORDS, beat counter width.
- One natural sub-module, mac_out_beat_select: combinational beat mux plus keep/zero masking from beat_cnt and words. Instantiated once.

Test Plan:
- Defaults, cfg_channels=256, one vector with words 0..7 = 0x00..07, s_last=1, m_tready=1 -> 8 beats on consecutive cycles, data 0x0..0x7, m_tkeep=4'hF, m_tlast only on beat 7, then vec_done and layer_done pulse once.
- cfg_channels=70 (3 words), BEAT_WORDS=2 -> 2 beats; beat 1 has tdata upper word=0 and m_tkeep=8'h0F; beat 0 has m_tkeep=8'hFF.
- m_tready toggling 1,0,0,1 during a 4-beat vector -> tdata/tkeep/tlast stable while stalled; beat sequence identical to the unstalled run; total of 6 tvalid cycles.
- Two vectors offered back-to-back with s_valid held high, m_tready=1, cfg_channels=64 -> beats A0,A1,B0,B1 with no tvalid gap; s_ready high on the A1 cycle; m_tlast only on B1 (B has s_last=1).
- cfg_channels=0 and cfg_channels=4095 -> 1 beat and 8 beats respectively (both clamps exercised).
- rst_n asserted during beat 2 of an 8-beat vector -> m_tvalid=0 immediately; after release the packer is in IDLE with s_ready=1, and a new vector streams from word 0.
